// File: rtl/seq_frame_pkg.sv
// Shared definitions for the serial frame link: state encoding, default
// preamble and the down-counter sizing helper.
package seq_frame_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t PRE  = 2'b01;
  localparam state_t DATA = 2'b10;
  localparam state_t GAP  = 2'b11;

  // Same pattern the far-end 1011 detector locks onto.
  localparam logic [3:0] DEF_PREAMBLE = 4'b1011;

  // Bits needed to count down from the longest phase, never fewer than one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_frame_tx_piso_shift.sv
// Parallel-in serial-out shift register; the MSB is always the bit on the line.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, data word MSB-first, then GAP_LEN zeros
// so an overlapping 1011 detector is back in its reset state between frames.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int                 WIDTH    = 8,
  parameter int                 PRE_LEN  = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = DEF_PREAMBLE,
  parameter int                 GAP_LEN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CW = cnt_width(WIDTH, PRE_LEN, GAP_LEN);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             data_bit;
  logic [PRE_LEN-1:0] pre_sel;

  assign accept = data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= PRE;
            cnt   <= PRE_LAST;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= DATA_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (state == DATA),
    .din   (data_in),
    .msb   (data_bit)
  );

  // Shifting instead of indexing keeps the select legal for any counter width.
  assign pre_sel = PREAMBLE >> cnt;

  always_comb begin
    sout = 1'b0;
    case (state)
      PRE:     sout = pre_sel[0];
      DATA:    sout = data_bit;
      default: sout = 1'b0;
    endcase
  end

  assign data_ready  = (state == IDLE);
  assign busy        = (state != IDLE);
  assign frame_start = (state == PRE) && (cnt == PRE_LAST);
  assign frame_done  = (state == GAP) && (cnt == '0);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: table of frames plus reset, idle and detector
// sequences, all checked bit-by-bit against a scoreboard of expected cycles.
module tb_seq_frame_tx;
  import seq_frame_pkg::*;

  localparam int W  = 8;
  localparam int P  = 4;
  localparam int G  = 2;
  localparam int FL = P + W + G;

  typedef struct {
    logic sout;
    logic start;
    logic done;
    int   idx;
  } exp_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [FL-1:0] frame;
    logic          hold;
    logic [W-1:0]  after;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, sout, busy, frame_start, frame_done;

  seq_frame_tx #(.WIDTH(W), .PRE_LEN(P), .PREAMBLE(DEF_PREAMBLE), .GAP_LEN(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .sout        (sout),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FL-1:0] build_frame(input logic [W-1:0] w);
    return {DEF_PREAMBLE, w, {G{1'b0}}};
  endfunction

  function automatic int count1011(input logic [FL-1:0] f);
    int n = 0;
    for (int i = FL - 1; i >= 3; i--)
      if (f[i -: 4] == 4'b1011) n++;
    return n;
  endfunction

  // Scoreboard: a whole frame is queued on each accepted handshake.
  exp_t          sb[$];
  exp_t          e;
  logic [FL-1:0] pending = '0;
  logic          model_ready = 1'b1;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            acc_cyc[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && data_valid && model_ready) begin
      for (int i = 0; i < FL; i++)
        sb.push_back('{pending[FL-1-i], (i == 0), (i == FL - 1), i});
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
  end

  // Far-end overlapping 1011 detector plus per-cycle output comparison.
  logic [3:0] hist = '0;
  int         det_cnt = 0;
  int         det_boundary = 0;
  int         start_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hist = '0;
      model_ready = 1'b1;
      check("rst_sout", sout, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", data_ready, 1);
      check("rst_start", frame_start, 0);
      check("rst_done", frame_done, 0);
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      model_ready = 1'b0;
      check("sout", sout, e.sout);
      check("frame_start", frame_start, e.start);
      check("frame_done", frame_done, e.done);
      check("busy", busy, 1);
      check("data_ready", data_ready, 0);
      hist = {hist[2:0], sout};
      if (hist == 4'b1011) begin
        det_cnt++;
        if (e.idx < 3) det_boundary++;
      end
    end else begin
      model_ready = 1'b1;
      check("idle_sout", sout, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", data_ready, 1);
      check("idle_start", frame_start, 0);
      check("idle_done", frame_done, 0);
      hist = {hist[2:0], sout};
      if (hist == 4'b1011) det_boundary++;
    end
    if (rst_n && frame_start) start_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 of the first cycle of the frame.
  task automatic send(input logic [W-1:0] d, input logic [FL-1:0] f,
                      input logic hold, input logic [W-1:0] after);
    int  n0;
    bit  got;
    n0 = acc_cnt;
    got = 1'b0;
    data_in = d;
    pending = f;
    data_valid = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) got = 1'b1;
    end
    check("accept_timeout", got, 1);
    data_in = after;
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || !model_ready) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", k < 100, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[4];
    int   s0, d0, exp_det;
    logic [W-1:0]  w;
    logic [FL-1:0] f;

    vt[0] = '{8'hA5, 14'b1011_1010_0101_00, 1'b0, 8'h5A};
    vt[1] = '{8'hFF, 14'b1011_1111_1111_00, 1'b1, 8'hC3};
    vt[2] = '{8'h00, 14'b1011_0000_0000_00, 1'b0, 8'hFF};
    vt[3] = '{8'h3C, 14'b1011_0011_1100_00, 1'b0, 8'h00};

    #1;
    check("reset_sout", sout, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", data_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send(vt[i].data, vt[i].frame, vt[i].hold, vt[i].after);
      if (i == 2) check("b2b_period", acc_cyc[$] - acc_cyc[$-1], FL + 1);
    end
    drain();

    // Reset while data bit 3 is on the line, then a clean frame.
    send(8'hA5, 14'b1011_1010_0101_00, 1'b0, 8'h00);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_sout", sout, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", data_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h5A, 14'b1011_0101_1010_00, 1'b0, 8'hFF);
    drain();

    // No valid: the line stays quiet.
    s0 = start_cnt;
    data_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("idle_no_start", start_cnt - s0, 0);

    // Random words into the detector model.
    d0 = det_cnt;
    exp_det = 0;
    for (int i = 0; i < 100; i++) begin
      w = W'($urandom);
      f = build_frame(w);
      exp_det += count1011(f);
      send(w, f, (i == 99) ? 1'b0 : 1'(($urandom_range(0, 1))), W'($urandom));
      if ($urandom_range(0, 3) == 0 && !data_valid) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    data_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("detections", det_cnt - d0, exp_det);
    check("boundary_dets", det_boundary, 0);
    check("start_count", start_cnt, acc_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
